// File: rtl/regfile_pkg.sv
// Constants shared by the register file, decode and the writeback arbiter:
// default widths, the hard-wired zero register and requester indices.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;

    // Index of each writeback source in two-bit request/grant vectors.
    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_idx_e;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == COUNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Valid/ready writeback request bundle for the ALU (0) and memory (1)
// sources; the sources drive the master side, the arbiter owns the slave side.
interface regfile_write_arbiter_if #(
    parameter int ADDR_W = regfile_pkg::ADDR_W_DEF,
    parameter int DATA_W = regfile_pkg::DATA_W_DEF
);

    logic              valid0;
    logic              ready0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] data0;

    logic              valid1;
    logic              ready1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data1;

    modport master (
        output valid0, addr0, data0,
        output valid1, addr1, data1,
        input  ready0, ready1
    );

    modport slave (
        input  valid0, addr0, data0,
        input  valid1, addr1, data1,
        output ready0, ready1
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-input grant logic. REGARB_RR_EN selects round-robin; otherwise req0
// has fixed priority and req1 is protected from starvation by a wait counter.
module rr_arbiter_2
    import regfile_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic prefer_mem;

`ifdef REGARB_RR_EN
    req_idx_e ptr;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= REQ_ALU;
        end else if (grant[REQ_ALU]) begin
            ptr <= REQ_MEM;
        end else if (grant[REQ_MEM]) begin
            ptr <= REQ_ALU;
        end
    end

    assign prefer_mem = (ptr == REQ_MEM);
`else
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    logic [WAIT_W-1:0] wait_cnt;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!req[REQ_MEM] || grant[REQ_MEM]) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Once req1 has lost MAX_WAIT conflicts in a row it takes the next one.
    assign prefer_mem = (wait_cnt == WAIT_W'(MAX_WAIT));
`endif

    // NOTE: grant gets a default first so no path through the block can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant = '0;
        if (req[REQ_MEM] && (!req[REQ_ALU] || prefer_mem)) begin
            grant[REQ_MEM] = 1'b1;
        end else if (req[REQ_ALU]) begin
            grant[REQ_ALU] = 1'b1;
        end
    end

    grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(grant));
    grant_needs_req: assert property (@(posedge clk) disable iff (!reset) (grant & ~req) == 2'b00);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between ALU and memory writeback:
// arbitration, registered write stage, RAW hazard flags and conflict counter.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  wb,
    input  logic [ADDR_W-1:0]       readAddress_1,
    input  logic [ADDR_W-1:0]       readAddress_2,
    output logic                    hazard_1,
    output logic                    hazard_2,
    output logic                    regWrite,
    output logic [ADDR_W-1:0]       writeAddress,
    output logic [DATA_W-1:0]       writeInputData,
    output logic [15:0]             conflictCount
);

    logic [1:0]        req;
    logic [1:0]        grant;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    assign req[REQ_ALU] = wb.valid0;
    assign req[REQ_MEM] = wb.valid1;

    rr_arbiter_2 #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    assign wb.ready0 = grant[REQ_ALU];
    assign wb.ready1 = grant[REQ_MEM];

    assign accept   = |grant;
    assign sel_addr = grant[REQ_MEM] ? wb.addr1 : wb.addr0;
    assign sel_data = grant[REQ_MEM] ? wb.data1 : wb.data0;

    // Writes to the zero register still complete the handshake and update
    // the address/data stage, but never raise the write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regWrite       <= 1'b0;
            writeAddress   <= '0;
            writeInputData <= '0;
        end else begin
            regWrite <= accept && (sel_addr != ADDR_W'(ZERO_REG));
            if (accept) begin
                writeAddress   <= sel_addr;
                writeInputData <= sel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conflictCount <= '0;
        end else if (wb.valid0 && wb.valid1) begin
            conflictCount <= sat_inc16(conflictCount);
        end
    end

    // A read hazards on the staged write and on either pending request.
    assign hazard_1 = (readAddress_1 != ADDR_W'(ZERO_REG)) &&
                      ((regWrite  && (writeAddress == readAddress_1)) ||
                       (wb.valid0 && (wb.addr0     == readAddress_1)) ||
                       (wb.valid1 && (wb.addr1     == readAddress_1)));

    assign hazard_2 = (readAddress_2 != ADDR_W'(ZERO_REG)) &&
                      ((regWrite  && (writeAddress == readAddress_2)) ||
                       (wb.valid0 && (wb.addr0     == readAddress_2)) ||
                       (wb.valid1 && (wb.addr1     == readAddress_2)));

endmodule
